// File: rtl/trans_pkg.sv
// Transaction word layout shared by the assembler and the validator's field decode.
package trans_pkg;

  localparam int unsigned TRANS_WIDTH     = 128;
  localparam int unsigned BYTES_PER_WORD  = 16;

  localparam int unsigned SENDER_MSB      = 127;
  localparam int unsigned SENDER_LSB      = 80;
  localparam int unsigned RECEIVER_MSB    = 79;
  localparam int unsigned RECEIVER_LSB    = 32;
  localparam int unsigned AMOUNT_MSB      = 31;
  localparam int unsigned AMOUNT_LSB      = 10;
  localparam int unsigned BLOCK_START_BIT = 9;

  typedef struct packed {
    logic [SENDER_MSB-SENDER_LSB:0]     sender;
    logic [RECEIVER_MSB-RECEIVER_LSB:0] receiver;
    logic [AMOUNT_MSB-AMOUNT_LSB:0]     amount;
    logic                               block_start;
    logic [BLOCK_START_BIT-1:0]         pass_thru;
  } trans_t;

  typedef enum logic {
    HOLD_IDLE,
    HOLD_OFFER
  } hold_state_e;

  function automatic logic amount_is_zero(input logic [TRANS_WIDTH-1:0] w);
    trans_t t;
    t = trans_t'(w);
    return (t.amount == '0);
  endfunction

endpackage

// File: rtl/trans_byte_packer.sv
// Byte-to-word packer: shift register, byte index, sof realignment and
// inter-byte timeout. Presents one completed word until the parent takes it.
module trans_byte_packer
  import trans_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic                   i_take,
  input  logic                   i_clear,
  output logic                   o_ready,
  output logic [TRANS_WIDTH-1:0] o_asm,
  output logic                   o_full,
  output logic                   o_drop
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [TRANS_WIDTH-1:0] r_asm;
  logic [IDX_W-1:0]       r_idx;
  logic [TW-1:0]          r_tcnt;
  logic                   r_full;
  logic                   r_ready;

  logic w_accept;
  logic w_realign;
  logic w_timeout;
  logic w_wrap;
  logic w_full_nx;

  always_comb begin
    w_accept  = i_valid && r_ready;
    w_realign = w_accept && i_sof && (r_idx != '0);
    w_timeout = TIMEOUT_EN && !w_accept && (r_idx != '0) && (r_tcnt == T_LAST);
    w_wrap    = w_accept && !w_realign && (r_idx == IDX_LAST);
    w_full_nx = (r_full && !i_take) || w_wrap;
  end

  // ready is registered from the next full state so a completed word stalls
  // the stream on the very edge it completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm   <= '0;
      r_idx   <= '0;
      r_tcnt  <= '0;
      r_full  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_full  <= w_full_nx;
      r_ready <= !w_full_nx;

      if (w_accept) begin
        r_asm <= {r_asm[TRANS_WIDTH-9:0], i_data};
      end else if (i_clear) begin
        r_asm <= '0;
      end

      if (w_realign) begin
        r_idx <= IDX_W'(1);
      end else if (w_accept) begin
        r_idx <= r_idx + IDX_W'(1);
      end else if (w_timeout) begin
        r_idx <= '0;
      end

      if (w_accept || (r_idx == '0) || w_timeout) begin
        r_tcnt <= '0;
      end else if (TIMEOUT_EN) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  assign o_ready = r_ready;
  assign o_asm   = r_asm;
  assign o_full  = r_full;
  assign o_drop  = w_realign || w_timeout;

endmodule

// File: rtl/trans_assembler.sv
// Packs an inbound byte stream into 128-bit transaction words and offers them
// on a valid/ack handshake. Optional TRANS_ASM_ZERO_FILTER_EN drops zero-amount words.
module trans_assembler
  import trans_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_sof_i,
  output logic [TRANS_WIDTH-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ack_i,
  output logic [CNT_WIDTH-1:0]   word_cnt_o,
  output logic [CNT_WIDTH-1:0]   drop_cnt_o
);

  hold_state_e r_state;
  hold_state_e w_state_nx;

  logic [TRANS_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]   r_word_cnt;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;

  logic [TRANS_WIDTH-1:0] w_asm;
  logic w_full;
  logic w_pdrop;
  logic w_zero;
  logic w_take;
  logic w_load;
  logic w_fdrop;
  logic w_acked;

  trans_byte_packer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_data  (in_data_i),
    .i_valid (in_valid_i),
    .i_sof   (in_sof_i),
    .i_take  (w_take),
    .i_clear (w_fdrop),
    .o_ready (in_ready_o),
    .o_asm   (w_asm),
    .o_full  (w_full),
    .o_drop  (w_pdrop)
  );

`ifdef TRANS_ASM_ZERO_FILTER_EN
  assign w_zero = amount_is_zero(w_asm);
`else
  assign w_zero = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_load     = 1'b0;
    w_fdrop    = 1'b0;
    w_acked    = 1'b0;
    // Filtered words never reach the holding register, whatever its state.
    if (w_full && w_zero) begin
      w_take  = 1'b1;
      w_fdrop = 1'b1;
    end
    unique case (r_state)
      HOLD_IDLE: begin
        if (w_full && !w_zero) begin
          w_load     = 1'b1;
          w_take     = 1'b1;
          w_state_nx = HOLD_OFFER;
        end
      end
      HOLD_OFFER: begin
        if (ack_i) begin
          w_acked = 1'b1;
          if (w_full && !w_zero) begin
            w_load = 1'b1;
            w_take = 1'b1;
          end else begin
            w_state_nx = HOLD_IDLE;
          end
        end
      end
      default: w_state_nx = HOLD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HOLD_IDLE;
      r_data     <= '0;
      r_word_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_data <= w_asm;
      end
      if (w_acked) begin
        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
      end
      r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(w_pdrop) + CNT_WIDTH'(w_fdrop);
    end
  end

  assign data_o     = r_data;
  assign valid_o    = (r_state == HOLD_OFFER);
  assign word_cnt_o = r_word_cnt;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: doc/trans_assembler.md
Name: trans_assembler

Overview:
- Transaction source for the validator interface: packs an inbound byte stream (host/UART side) into 128-bit transaction words.
- Offers each word on the data/valid/ack handshake the validator consumes.
- Double-buffered: one word is held for the consumer while the next is assembled.
- Inter-byte timeout resynchronises the stream after truncated frames.

Parameters:
- TIMEOUT_CYCLES, 1024, idle cycles between bytes of a partial word before it is discarded; 0 disables the timeout.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data_i  in  8  stream byte; byte 0 = data_o[127:120] (MSB first)
- in_valid_i  in  1  in_data_i valid
- in_ready_o  out  1  byte accepted on an edge where in_valid_i && in_ready_o
- in_sof_i  in  1  qualifies a byte as the first of a word; forces realignment
- data_o  out  128  transaction word: [127:80] sender id, [79:32] receiver id, [31:10] amount, [9] block start, [8:0] pass-through
- valid_o  out  1  data_o holds a word awaiting ack
- ack_i  in  1  single-cycle acknowledge from the consumer
- word_cnt_o  out  CNT_WIDTH  words acknowledged by the consumer, wraps
- drop_cnt_o  out  CNT_WIDTH  partial words discarded, wraps

Behaviour:
- Reset (async assert, sync release): valid_o=0, data_o=0, in_ready_o=0 during reset and 1 the cycle after release, counters=0, byte index=0, timeout counter=0, both buffers empty.
- Assembly register (asm_q) plus byte index 0..15. An accepted byte shifts into asm_q: asm_q <= {asm_q[119:0], in_data_i}. Index increments and wraps 15->0; at wrap, asm_full=1.
- in_sof_i on an accepted byte with index != 0: the partial word is discarded and drop_cnt increments. The byte is stored as byte 0 and index becomes 1. in_sof_i with index==0 is a normal byte.
- Holding register (data_o/valid_o) states:
  - IDLE: valid_o=0. If asm_full, load data_o<=asm_q, valid_o<=1, clear asm_full -> OFFER.
  - OFFER: data_o stable while valid_o=1. On an edge with ack_i=1: word_cnt++. If asm_full on that same edge, load the new word with valid_o held at 1 (back-to-back) and stay in OFFER; else valid_o<=0 -> IDLE.
  - ack_i while in IDLE is ignored; no counter change.
- in_ready_o = !(asm_full), registered. With asm_full set and the holding register occupied, the stream stalls.
- Completing byte 15 in the same cycle the holding register frees: both take effect. The word may move to the holding register one cycle later. No byte is lost; in_ready_o deasserts at most one cycle.
- Latency: last byte accepted at edge N -> valid_o=1 after edge N+1 (holding register empty).
- Timeout:
  - The counter runs while index != 0 and no byte is accepted, and clears on each accepted byte.
  - At TIMEOUT_CYCLES: index<=0, partial word dropped, drop_cnt++.
  - The timeout does not touch asm_full or the holding register.
- Counter wrap: all-ones + 1 -> 0, no saturation.
- Reset mid-offer: word lost and valid_o drops immediately. The consumer's ack is registered, so a late ack after reset release hits IDLE and is ignored.

Optional Feature:
- Macro TRANS_ASM_ZERO_FILTER_EN.
- Defined: a completed word with amount field [31:10]==0 is not moved to the holding register. It is cleared from asm_q and drop_cnt increments.
- Undefined: zero-amount words are offered like any other word; the consumer decides.

Decomposition:
- Package trans_pkg holds:
  - field LSB/MSB constants: SENDER_MSB=127, SENDER_LSB=80, RECEIVER_MSB=79, RECEIVER_LSB=32, AMOUNT_MSB=31, AMOUNT_LSB=10, BLOCK_START_BIT=9
  - TRANS_WIDTH=128, BYTES_PER_WORD=16
  - typedef trans_t (packed struct of the fields)
- Shared with the validator's field decode.
- One sub-module, trans_byte_packer: byte index, shift register, sof realign, timeout. The parent keeps the holding register, handshake and counters.

Test Plan:
- 16 bytes 0x00..0x0F, ack_i pulsed 3 cycles after valid_o -> data_o=128'h000102..0F, valid_o high until ack edge, word_cnt_o=1.
- Two words streamed back-to-back, ack delayed 40 cycles:
  - in_ready_o low after byte 31 until the ack edge;
  - second word on data_o the cycle after ack with valid_o staying 1;
  - word_cnt_o=2.
- 5 bytes, then in_sof_i byte 0xAA plus 15 bytes -> drop_cnt_o=1, data_o[127:120]=8'hAA.
- TIMEOUT_CYCLES=8; 3 bytes, gap 8 cycles, then 16 bytes -> drop_cnt_o=1, word equals the 16 new bytes.
- Word with [31:10]=0:
  - macro defined -> valid_o never rises, drop_cnt_o=1;
  - undefined -> offered, word_cnt_o=1 after ack.
- rst asserted while valid_o=1 -> valid_o=0 same cycle (async); ack_i after release ignored; counters 0.
